// File: rtl/adder_share_arb_if.sv
// Requester/adder/response bundle for the shared-adder arbiter.
// slave = arbiter side, master = requesters + adder + response consumer.
interface adder_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0][31:0]   req_a;
  logic [N_REQ-1:0][31:0]   req_b;
  logic [N_REQ-1:0]         req_cin;
  logic                     flush;
  logic [N_REQ-1:0]         gnt;
  logic [31:0]              add_a;
  logic [31:0]              add_b;
  logic                     add_cin;
  logic [31:0]              add_s;
  logic                     add_cout;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_sum;
  logic                     rsp_cout;

  modport slave (
    input  req, req_a, req_b, req_cin, flush, add_s, add_cout,
    output gnt, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport master (
    output req, req_a, req_b, req_cin, flush, add_s, add_cout,
    input  gnt, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin front end for one shared fixed-latency prefix adder: grants one
// requester per cycle, registers its operands, and tags the result with its ID.
module adder_share_arb #(
  parameter int N_REQ     = 4,
  parameter int ADDER_LAT = 5,
  parameter int ID_W      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  adder_share_arb_if.slave  bus
);

  logic [ID_W-1:0]                 ptr_q, ptr_d;
  logic                            gnt_any;
  logic [ID_W-1:0]                 gnt_idx;
  logic [N_REQ-1:0]                gnt_vec;
  int                              cand;

  logic [31:0]                     add_a_q, add_b_q;
  logic                            add_cin_q;
  // Index 0 is the issue stage (operands in the adder), index ADDER_LAT is the response.
  logic [ADDER_LAT:0]              vld_pipe_q;
  logic [ADDER_LAT:0][ID_W-1:0]    id_pipe_q;

  // First asserted request at or after ptr, wrapping; reset and flush block grants.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    cand    = 0;
    if (!rst_i && !bus.flush) begin
      for (int off = 0; off < N_REQ; off++) begin
        cand = (int'(ptr_q) + off) % N_REQ;
        if (!gnt_any && bus.req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(cand);
        end
      end
      if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (gnt_any) begin
        add_a_q   <= bus.req_a[gnt_idx];
        add_b_q   <= bus.req_b[gnt_idx];
        add_cin_q <= bus.req_cin[gnt_idx];
      end
      // The adder never stalls, so tags advance every cycle; flush only kills valids.
      if (bus.flush) vld_pipe_q <= '0;
      else           vld_pipe_q <= {vld_pipe_q[ADDER_LAT-1:0], gnt_any};
      id_pipe_q <= {id_pipe_q[ADDER_LAT-1:0], gnt_idx};
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.rsp_valid = vld_pipe_q[ADDER_LAT];
  assign bus.rsp_id    = id_pipe_q[ADDER_LAT];
  assign bus.rsp_sum   = bus.add_s;
  assign bus.rsp_cout  = bus.add_cout;

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench: stimulus side predicts grants and pushes expected results;
// a monitor pops and compares whenever a response is due or presented.
module tb_adder_share_arb;
  localparam int N  = 4;
  localparam int L  = 5;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_share_arb_if #(.N_REQ(N), .ID_W(IW)) bus ();

  adder_share_arb #(.N_REQ(N), .ADDER_LAT(L), .ID_W(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Environment adder: L-cycle pipeline of a+b+cin.
  logic [32:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};
    for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
  end
  assign bus.add_s    = apipe[L-1][31:0];
  assign bus.add_cout = apipe[L-1][32];

  typedef struct {
    int          due;
    int          id;
    logic [32:0] res;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mptr   = 0;
  logic started = 1'b0;

  logic [N-1:0]       pend;
  logic [N-1:0][31:0] op_a, op_b;
  logic [N-1:0]       op_cin;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    pend[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
    op_cin[i] = c;
  endtask

  // One clock cycle: drive, predict grant at negedge, update model, return at posedge+1.
  task automatic step(input logic fl);
    logic [N-1:0] exp_g;
    int gi;
    bus.flush   = fl;
    bus.req     = pend;
    bus.req_a   = op_a;
    bus.req_b   = op_b;
    bus.req_cin = op_cin;
    @(negedge clk);
    exp_g = '0;
    gi = -1;
    if (!fl) begin
      for (int k = 0; k < N; k++) begin
        if (gi < 0 && pend[(mptr + k) % N]) gi = (mptr + k) % N;
      end
    end
    if (gi >= 0) exp_g[gi] = 1'b1;
    check("gnt", 64'(bus.gnt), 64'(exp_g));
    if (fl) begin
      for (int j = q.size() - 1; j >= 0; j--) if (q[j].due > cyc) q.delete(j);
    end
    if (gi >= 0) begin
      q.push_back('{cyc + L + 1, gi,
                    {1'b0, op_a[gi]} + {1'b0, op_b[gi]} + {32'd0, op_cin[gi]}});
      mptr = (gi + 1) % N;
      pend[gi] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  // Monitor: every cycle compare presence of a response and its contents.
  always @(negedge clk) begin
    if (started && !rst) begin
      logic exp_v;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
      if (exp_v) begin
        check("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
        check("rsp_sum", 64'(bus.rsp_sum), 64'(q[0].res[31:0]));
        check("rsp_cout", 64'(bus.rsp_cout), 64'(q[0].res[32]));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    pend = '0;
    op_a = '0;
    op_b = '0;
    op_cin = '0;
    bus.flush = 1'b0;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", 64'(bus.gnt), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("reset_add_a", 64'(bus.add_a), 64'd0);
    check("reset_add_cin", 64'(bus.add_cin), 64'd0);
    rst = 1'b0;
    started = 1'b1;

    // Single add: 23 + 11 + 1
    set_req(0, 32'd23, 32'd11, 1'b1);
    step(1'b0);
    idle(8);

    // Carry-out
    set_req(1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    step(1'b0);
    idle(8);

    // Fairness: all requesters held high
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, $urandom, $urandom, 1'($urandom));
      step(1'b0);
    end
    pend = '0;
    idle(8);

    // Pointer skip: grant 2, then only 1 and 3
    set_req(2, $urandom, $urandom, 1'b0);
    step(1'b0);
    set_req(1, $urandom, $urandom, 1'b1);
    set_req(3, $urandom, $urandom, 1'b0);
    step(1'b0);
    step(1'b0);
    idle(8);

    // Flush two cycles after the last of three grants, req[2] waiting
    set_req(0, $urandom, $urandom, 1'b1);
    set_req(1, $urandom, $urandom, 1'b0);
    set_req(3, $urandom, $urandom, 1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    set_req(2, $urandom, $urandom, 1'b1);
    step(1'b1);
    step(1'b0);
    idle(8);

    // Random traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && ($urandom_range(2) == 0)) set_req(i, $urandom, $urandom, 1'($urandom));
      step(1'($urandom_range(15) == 0));
    end

    // Async reset mid-flight
    for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, $urandom, $urandom, 1'($urandom));
    step(1'b0);
    step(1'b0);
    set_req(2, $urandom, $urandom, 1'b0);
    step(1'b0);
    rst = 1'b1;
    #1;
    check("midreset_gnt", 64'(bus.gnt), 64'd0);
    check("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midreset_rsp_id", 64'(bus.rsp_id), 64'd0);
    q.delete();
    mptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && ($urandom_range(3) == 0)) set_req(i, $urandom, $urandom, 1'($urandom));
      step(1'($urandom_range(19) == 0));
    end

    pend = '0;
    idle(L + 3);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and tag tracker that shares the single pipelined 32-bit prefix adder among N_REQ requesters (ALU, address generation, branch-target unit, ...). Each cycle it grants at most one requester, registers that requester's operands into the adder inputs, and carries a valid/ID tag alongside the adder's fixed-latency pipeline. When the sum emerges, it is returned with the owning requester's ID. Sits directly in front of the prefix adder in the processor datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDER_LAT, 5, adder latency in cycles: operands on add_a/add_b/add_cin in cycle k produce add_s/add_cout in cycle k+ADDER_LAT (≥1)
- ID_W, 2, width of requester ID, = clog2(N_REQ)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request; held until granted
- req_a  in  32*N_REQ  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*N_REQ  operand B, same packing
- req_cin  in  N_REQ  carry-in per requester
- flush  in  1  kill all in-flight operations and block new grants this cycle
- gnt  out  N_REQ  one-hot grant, combinational; request accepted this cycle
- add_a, add_b  out  32  registered operands to adder
- add_cin  out  1  registered carry-in to adder
- add_s  in  32  adder sum
- add_cout  in  1  adder carry-out
- rsp_valid  out  1  response valid
- rsp_id  out  ID_W  requester owning the response
- rsp_sum  out  32  equals add_s
- rsp_cout  out  1  equals add_cout

## Operation
- Arbitration: round-robin pointer ptr (ID_W bits). gnt selects the first asserted req[i] searching ptr, ptr+1, … wrapping modulo N_REQ. On any grant, ptr ← granted index + 1 (mod N_REQ); without a grant, ptr holds.
- gnt is all-zero when reset or flush is high or req == 0. At most one bit is ever set.
- Issue register: on a grant, add_a/add_b/add_cin ← granted requester's operands; the internal issue valid ← 1 and issue id ← granted index. Without a grant, the issue valid ← 0 and the operand registers hold their values.
- Tag pipe: ADDER_LAT stages of {valid, id}, fed from {issue valid, issue id} and advancing every cycle. There is no stall, because the adder itself never stalls.
- Response: rsp_valid/rsp_id = the last tag stage. rsp_sum/rsp_cout pass add_s/add_cout through combinationally.
- Flush (synchronous): at the clock edge, the issue valid and all tag-stage valids ← 0. No grant is issued in the flush cycle. The operand registers and ptr hold.
- Reset (asynchronous): ptr ← 0, add_a/add_b/add_cin ← 0, issue valid and all tag valids ← 0, ids ← 0. Outputs in reset: gnt = 0, rsp_valid = 0, rsp_id = 0. Reset mid-operation discards all in-flight work; no response appears for it.
- Arithmetic: the block does no arithmetic. Sum and carry are exactly the adder's. The 33-bit result {rsp_cout, rsp_sum} = a + b + cin.

## Timing
- Cycle t: req[i] high and selected, so gnt[i] = 1 in t. The requester may change or drop its request from t+1.
- Cycle t+1: add_a/add_b/add_cin hold operands; the issue valid is set.
- Cycle t+1+ADDER_LAT: rsp_valid = 1, rsp_id = i, and rsp_sum/rsp_cout are the result. Total latency from grant cycle to response = ADDER_LAT+1.
- Throughput: one grant per cycle. Back-to-back grants give back-to-back responses in grant order.
- Simultaneous flush and req: flush wins, gnt = 0, and ptr is unchanged.
- A flush in cycle f kills every grant made in cycles ≤ f−1 whose response would appear after f. A response already on rsp_valid during cycle f is still valid in cycle f.
- Wrap-around: ptr = N_REQ−1 with grant → ptr = 0.

## Test plan
- Single add: reset, then req[0] = 1 with a = 23, b = 11, cin = 1 for one cycle → gnt = 4'b0001 in that cycle; 6 cycles later (ADDER_LAT = 5), rsp_valid = 1, rsp_id = 0, rsp_sum = 35, rsp_cout = 0, for exactly one cycle.
- Fairness: all four req held high continuously with distinct operands → gnt sequence 0001, 0010, 0100, 1000, 0001…; responses appear every cycle with rsp_id 0, 1, 2, 3, 0… and correct sums.
- Pointer wrap/skip: after a grant to requester 2, only req[1] and req[3] high → requester 3 is granted first, then requester 1.
- Carry-out: a = 32'hFFFFFFFF, b = 0, cin = 1 from requester 1 → rsp_sum = 0, rsp_cout = 1, rsp_id = 1.
- Flush: grant three ops in consecutive cycles, then assert flush two cycles after the last grant, with req[2] high during flush → gnt = 0 during flush; no rsp_valid for the three killed ops; req[2] is granted the cycle after flush.
- Async reset mid-flight: assert reset between clock edges while ops are in flight → rsp_valid and gnt drop to 0 immediately; after release, no stale responses appear, and the first grant goes to the lowest-index active requester (ptr = 0).
